// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions two asynchronous, bouncing push-button inputs. Each channel is
//   synchronized, debounced by its own 4-state FSM and checked for long
//   presses. Press events from both channels share one arbiter, so push_pulse
//   has at most one bit set in any cycle.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : synchronous, active-high reset
//   push_raw    : [1:0] asynchronous raw button inputs, 1 = pressed
//   push_level  : [1:0] debounced button level per channel
//   push_pulse  : [1:0] one-cycle press pulse, never 2'b11
//   long_pulse  : [1:0] one-cycle pulse when a press has lasted LONG_CYCLES
//   dbg_state_o : [3:0] per-channel FSM state, {ch1, ch0}, 2 bits each
//
// Handshake
//   There is no valid/ready flow control. Each output pulse is a single-cycle
//   event that the consumer must sample in the cycle it is high.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_300_000,
  parameter int unsigned LONG_CYCLES     = 130_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] push_raw,
  output logic [1:0] push_level,
  output logic [1:0] push_pulse,
  output logic [1:0] long_pulse,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [31:0] DEB_M1   = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_M1  = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] LONG_MAX = 32'(LONG_CYCLES);

  // Two-flop synchronizer for both raw inputs.
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= push_raw;
      sync2_q <= sync1_q;
    end
  end

  logic [1:0] req_w;
  logic [1:0] level_w;
  logic [1:0] long_w;

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    state_e      state_q;
    logic [31:0] cnt_q;
    logic        level_q;
    logic        req_q;
    logic        long_q;
    logic        fired_q;
    logic        synced;
    logic [31:0] cnt_inc;

    assign synced  = sync2_q[ch];
    assign cnt_inc = cnt_q + 32'd1;

    // The debounce checks compare the incremented count, so the transition
    // edge is the one on which the counter would reach DEBOUNCE_CYCLES-1.
    // That places push_level DEBOUNCE_CYCLES cycles after the synced edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
        req_q   <= 1'b0;
        long_q  <= 1'b0;
        fired_q <= 1'b0;
      end else begin
        req_q  <= 1'b0;
        long_q <= 1'b0;
        case (state_q)
          RELEASED: begin
            if (synced) begin
              state_q <= PRESS_WAIT;
              cnt_q   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!synced) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (cnt_inc >= DEB_M1) begin
              state_q <= PRESSED;
              level_q <= 1'b1;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              fired_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          PRESSED: begin
            if (!synced) begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= '0;
            end else begin
              // fired_q survives release bounces, so one press fires once.
              if (cnt_q == LONG_M1 && !fired_q) begin
                long_q  <= 1'b1;
                fired_q <= 1'b1;
              end
              if (cnt_q < LONG_MAX) begin
                cnt_q <= cnt_inc;
              end
            end
          end
          RELEASE_WAIT: begin
            if (synced) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_inc >= DEB_M1) begin
              state_q <= RELEASED;
              level_q <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign req_w[ch]                  = req_q;
    assign level_w[ch]                = level_q;
    assign long_w[ch]                 = long_q;
    assign dbg_state_o[2*ch+1 : 2*ch] = state_q;
  end

  // Arbiter: pending requests are served before new ones; channel 0 wins ties.
  // A new request on a channel that already has one pending is absorbed into
  // that pending flag, so at most one request per channel is ever deferred.
  logic [1:0] pend_q;
  logic [1:0] pend_d;
  logic [1:0] grant_d;
  logic [1:0] pulse_q;

  always_comb begin
    grant_d = 2'b00;
    if (pend_q[0]) begin
      grant_d = 2'b01;
    end else if (pend_q[1]) begin
      grant_d = 2'b10;
    end else if (req_w[0]) begin
      grant_d = 2'b01;
    end else if (req_w[1]) begin
      grant_d = 2'b10;
    end
    pend_d = (req_w | pend_q) & ~grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      pulse_q <= '0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= grant_d;
    end
  end

  assign push_level = level_w;
  assign push_pulse = pulse_q;
  assign long_pulse = long_w;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] push_raw;
  logic [1:0] push_level;
  logic [1:0] push_pulse;
  logic [1:0] long_pulse;
  logic [3:0] dbg_state_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] cyc = '0;

  // Entries are {cycle, value}: the pulse value expected at that cycle.
  logic [33:0] exp_q[$];
  logic [33:0] exp_long_q[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push_raw   (push_raw),
    .push_level (push_level),
    .push_pulse (push_pulse),
    .long_pulse (long_pulse),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_check(input int n, input logic [1:0] lvl, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(1);
      check(tag, 32'(push_level), 32'(lvl));
    end
  endtask

  task automatic expect_pulse(input int unsigned dly, input logic [1:0] val);
    exp_q.push_back({cyc + 32'(dly), val});
  endtask

  task automatic expect_long(input int unsigned dly, input logic [1:0] val);
    exp_long_q.push_back({cyc + 32'(dly), val});
  endtask

  // Scoreboard monitor: compares every pulse against the expected queues,
  // and flags expected pulses whose cycle has passed without appearing.
  initial begin
    logic [33:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0 && exp_q[0][33:2] < cyc) begin
        e = exp_q.pop_front();
        check("pulse_missed", 32'(2'b00), 32'(e[1:0]));
      end
      if (push_pulse !== 2'b00) begin
        check("pulse_not_both", 32'(push_pulse == 2'b11), 32'd0);
        if (exp_q.size() == 0) begin
          check("pulse_unexpected", 32'(push_pulse), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e[33:2]);
          check("pulse_value", 32'(push_pulse), 32'(e[1:0]));
        end
      end
      if (exp_long_q.size() > 0 && exp_long_q[0][33:2] < cyc) begin
        e = exp_long_q.pop_front();
        check("long_missed", 32'(2'b00), 32'(e[1:0]));
      end
      if (long_pulse !== 2'b00) begin
        if (exp_long_q.size() == 0) begin
          check("long_unexpected", 32'(long_pulse), 32'd0);
        end else begin
          e = exp_long_q.pop_front();
          check("long_cycle", cyc, e[33:2]);
          check("long_value", 32'(long_pulse), 32'(e[1:0]));
        end
      end
    end
  end

  int glitch_lvl[6] = '{1, 0, 1, 0, 1, 0};
  int glitch_len[6] = '{1, 2, 2, 2, 3, 3};

  initial begin
    reset    = 1'b1;
    push_raw = 2'b00;
    tick(3);
    check("rst_level", 32'(push_level), 32'd0);
    check("rst_pulse", 32'(push_pulse), 32'd0);
    check("rst_long", 32'(long_pulse), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'd0);
    reset = 1'b0;
    tick(2);

    // Clean press on channel 0, held 10 cycles.
    push_raw = 2'b01;
    expect_pulse(7, 2'b01);
    tick(5);
    check("clean_level_early", 32'(push_level), 32'd0);
    tick(1);
    check("clean_level_rise", 32'(push_level), 32'd1);
    tick(4);
    push_raw = 2'b00;
    tick(5);
    check("clean_level_hold", 32'(push_level), 32'd1);
    tick(1);
    check("clean_level_fall", 32'(push_level), 32'd0);
    tick(4);

    // Bouncing press on channel 1.
    for (int i = 0; i < 6; i++) begin
      push_raw = (glitch_lvl[i] != 0) ? 2'b10 : 2'b00;
      run_check(glitch_len[i], 2'b00, "bounce_level_low");
    end
    push_raw = 2'b10;
    expect_pulse(7, 2'b10);
    run_check(5, 2'b00, "bounce_level_wait");
    tick(1);
    check("bounce_level_rise", 32'(push_level), 32'd2);
    tick(6);
    push_raw = 2'b00;
    tick(6);
    check("bounce_level_fall", 32'(push_level), 32'd0);
    tick(4);

    // Simultaneous press on both channels.
    push_raw = 2'b11;
    expect_pulse(7, 2'b01);
    expect_pulse(8, 2'b10);
    tick(6);
    check("simul_level", 32'(push_level), 32'd3);
    tick(4);
    push_raw = 2'b00;
    tick(6);
    check("simul_level_fall", 32'(push_level), 32'd0);
    tick(4);

    // Long press on channel 0, held 30 cycles.
    push_raw = 2'b01;
    expect_pulse(7, 2'b01);
    expect_long(DEB + 2 + LNG, 2'b01);
    tick(6);
    check("long_level_rise", 32'(push_level), 32'd1);
    tick(24);
    push_raw = 2'b00;
    tick(6);
    check("long_level_fall", 32'(push_level), 32'd0);
    tick(4);

    // Release bounce on channel 1.
    push_raw = 2'b10;
    expect_pulse(7, 2'b10);
    tick(5);
    check("relb_level_early", 32'(push_level), 32'd0);
    tick(1);
    check("relb_level_rise", 32'(push_level), 32'd2);
    run_check(6, 2'b10, "relb_level_held");
    push_raw = 2'b00;
    run_check(2, 2'b10, "relb_glitch_low");
    push_raw = 2'b10;
    run_check(6, 2'b10, "relb_glitch_after");
    push_raw = 2'b00;
    run_check(5, 2'b10, "relb_final_wait");
    tick(1);
    check("relb_level_fall", 32'(push_level), 32'd0);
    tick(4);

    // Reset mid-debounce with the button still held.
    push_raw = 2'b01;
    tick(5);
    reset = 1'b1;
    tick(1);
    check("mid_rst_level", 32'(push_level), 32'd0);
    check("mid_rst_pulse", 32'(push_pulse), 32'd0);
    check("mid_rst_long", 32'(long_pulse), 32'd0);
    check("mid_rst_state", 32'(dbg_state_o), 32'd0);
    reset = 1'b0;
    expect_pulse(7, 2'b01);
    run_check(5, 2'b00, "mid_rst_level_wait");
    tick(1);
    check("mid_rst_level_rise", 32'(push_level), 32'd1);
    tick(4);
    push_raw = 2'b00;
    tick(15);

    check("pulse_queue_empty", 32'(exp_q.size()), 32'd0);
    check("long_queue_empty", 32'(exp_long_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
